// File: rtl/soc_mem_reader_pkg.sv
// Shared constants and FSM state type for the on-chip memory read master.
package soc_mem_reader_pkg;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 2560;
  localparam int COUNT_W   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/soc_mem_reader_fifo.sv
// Small show-ahead FIFO: the head entry is visible on rd_data whenever not empty.
module soc_mem_reader_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [PTR_W:0]   count
);
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];

  // Storage is not reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/soc_mem_reader.sv
// Avalon-MM read master streaming a block of on-chip memory words as one
// Avalon-ST packet, with credit-limited issue into a small output FIFO.
module soc_mem_reader #(
  parameter int ADDR_W     = soc_mem_reader_pkg::ADDR_W,
  parameter int DATA_W     = soc_mem_reader_pkg::DATA_W,
  parameter int MEM_WORDS  = soc_mem_reader_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [12:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);
  import soc_mem_reader_pkg::*;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 2;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [COUNT_W-1:0]  issue_left_reg, count_reg, push_idx_reg;
  logic                inflight_reg, done_reg;
  logic                issue, credit_ok, accept, zero_start, eop_pop, pop;
  logic [PTR_W:0]      fifo_count;
  logic                fifo_empty;
  logic [OCC_W-1:0]    occupancy;
  logic [DATA_W+1:0]   fifo_in, fifo_head;

  // Words buffered plus the one possibly in flight must never exceed the FIFO.
  assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight_reg);
  assign credit_ok  = occupancy < OCC_W'(FIFO_DEPTH);
  assign accept     = (state_reg == IDLE) && start && !abort && (word_count != '0);
  assign zero_start = (state_reg == IDLE) && start && !abort && (word_count == '0);
  assign pop        = st_valid && st_ready;
  assign eop_pop    = pop && st_eop;
  assign addr_next  = (addr_reg == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = RUN;
      RUN: begin
        if (abort)                             state_next = IDLE;
        else if (issue && issue_left_reg == 1) state_next = DRAIN;
      end
      DRAIN: begin
        if (abort)        state_next = IDLE;
        else if (eop_pop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_reg != IDLE);
    issue = (state_reg == RUN) && credit_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_reg       <= '0;
      issue_left_reg <= '0;
      count_reg      <= '0;
      push_idx_reg   <= '0;
      inflight_reg   <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      inflight_reg <= issue && !abort;
      done_reg     <= zero_start || ((state_reg == DRAIN) && !abort && eop_pop);
      if (accept) begin
        addr_reg       <= base_addr;
        issue_left_reg <= word_count;
        count_reg      <= word_count;
        push_idx_reg   <= '0;
      end else begin
        if (issue) begin
          addr_reg       <= addr_next;
          issue_left_reg <= issue_left_reg - 1'b1;
        end
        if (inflight_reg) push_idx_reg <= push_idx_reg + 1'b1;
      end
    end
  end

  // Packet position is tagged on push so the stream side needs no counters.
  assign fifo_in = {mem_readdata,
                    (push_idx_reg == '0),
                    (push_idx_reg == count_reg - 1'b1)};

  soc_mem_reader_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort && busy),
    .push    (inflight_reg),
    .pop     (pop),
    .wr_data (fifo_in),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign st_valid       = !fifo_empty;
  assign st_data        = fifo_head[DATA_W+1:2];
  assign st_sop         = st_valid && fifo_head[1];
  assign st_eop         = st_valid && fifo_head[0];
  assign done           = done_reg;
  assign mem_address    = addr_reg;
  assign mem_chipselect = issue;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
endmodule

// File: doc/soc_mem_reader.md
# soc_mem_reader

Avalon-MM read master for the 32-bit port of the dual-port on-chip memory. Given a start word address and a word count, it issues single-word reads with fixed one-cycle read latency and delivers the returned words as an Avalon-ST packet with ready/valid backpressure. Credit-based issue plus a small show-ahead FIFO lets it sustain one word per cycle without losing data under backpressure. It sits between the memory's 32-bit port and downstream stream consumers in the receiver datapath.

## Interface
- ADDR_W, 12, memory word-address width
- DATA_W, 32, data width
- MEM_WORDS, 2560, memory depth in words; address wrap point
- FIFO_DEPTH, 4, output FIFO entries; power of two, must be at least 4
- clk  in  1  sole clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  launch a transfer; sampled only in IDLE
- abort  in  1  cancel the current transfer
- base_addr  in  ADDR_W  first word address; must be below MEM_WORDS
- word_count  in  13  words to read, 0..MEM_WORDS
- busy  out  1  state is not IDLE
- done  out  1  one-cycle completion pulse
- mem_address  out  ADDR_W  read address
- mem_chipselect  out  1  read strobe, one word per cycle
- mem_clken  out  1  tied to 1
- mem_write  out  1  tied to 0
- mem_byteenable  out  4  tied to 4'hF
- mem_readdata  in  DATA_W  valid exactly one cycle after its chipselect cycle
- st_data  out  DATA_W  stream data
- st_valid / st_ready  out / in  1  stream handshake
- st_sop / st_eop  out  1  first / last word of the packet

## Operation
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, st_valid=0, st_sop=0, st_eop=0; FIFO empty; state IDLE.
- States:
  - IDLE: on start with word_count≠0, latch base_addr and word_count, then go to RUN. On start with word_count=0, pulse done on the next cycle, issue no reads, and stay in IDLE.
  - RUN: issue a read in any cycle where fifo_count + inflight < FIFO_DEPTH. After the last read is issued, go to DRAIN.
  - DRAIN: on the handshake of the eop beat, go to IDLE and pulse done in the first IDLE cycle.
- start while busy is ignored.
- Address increments by 1 per issued read. After MEM_WORDS-1 it wraps to 0, never to 2^ADDR_W.
- inflight is 1 in the cycle after an issue. The returned word is pushed into the FIFO unconditionally; the credit rule guarantees it is never full.
- Tag words with their packet position as they are pushed:
  - sop on word index 0;
  - eop on word index word_count-1;
  - both on the same beat when word_count=1.
- Stream: st_data, st_sop, st_eop and st_valid come from the FIFO head. Pop when st_valid && st_ready. Outputs hold stable while valid && !ready.
- abort in RUN or DRAIN: the next cycle is IDLE with the FIFO flushed and st_valid=0. The in-flight return is discarded and done is not pulsed. abort in IDLE has no effect. abort and start in the same cycle: abort wins.
- reset_n low at any time forces the reset values on the next edge, including mid-transfer.

## Timing
- start accepted at edge 0 → first mem_chipselect in cycle 1 → first st_valid in cycle 3.
- With st_ready held high: one word per cycle; last beat in cycle word_count+2; done in cycle word_count+3.
- Backpressure: issue stops once FIFO_DEPTH words are buffered or in flight. Issue resumes the cycle after the first pop.
- A push and a pop in the same cycle leave fifo_count unchanged.

## Structure
- Package soc_mem_reader_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - MEM_WORDS, ADDR_W, DATA_W constants.
- Sub-module soc_mem_reader_fifo:
  - synchronous show-ahead FIFO;
  - DATA_W+2 bits wide (data, sop, eop);
  - exports count;
  - has a flush input.

## Test plan
- base=0, count=4, ready=1 → addresses 0,1,2,3 in cycles 1–4; st_valid in cycles 3–6 with data mem[0..3]; sop on mem[0], eop on mem[3]; done in cycle 7.
- base=10, count=8, ready=0 → exactly 4 reads issued, then mem_chipselect=0. Raise ready → all 8 words arrive in order with no loss or duplication.
- base=2558, count=4 → addresses 2558, 2559, 0, 1.
- count=1 → single beat with sop=eop=1. count=0 → no chipselect, done pulses in cycle 1, busy stays 0.
- abort after 2 beats of a count=16 transfer → st_valid=0 the next cycle, no done. A following start with base=0, count=2 completes correctly.
- reset_n low mid-transfer → all outputs at reset values on the next cycle; a new start then works.
